// File: rtl/median_window_gen.sv
// 3x3 sliding-window generator for a raster pixel stream: two line buffers plus a
// registered shift window, feeding the median network's X1..X9 inputs.
module median_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic [DATA_W-1:0] X1,
    output logic [DATA_W-1:0] X2,
    output logic [DATA_W-1:0] X3,
    output logic [DATA_W-1:0] X4,
    output logic [DATA_W-1:0] X5,
    output logic [DATA_W-1:0] X6,
    output logic [DATA_W-1:0] X7,
    output logic [DATA_W-1:0] X8,
    output logic [DATA_W-1:0] X9,
    output logic              win_valid,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];

    // Stage p0: position of the incoming pixel and line-buffer reads at that column.
    // pix_sof forces (0,0) so a new frame always starts aligned.
    logic [CW-1:0]     col_p0;
    logic [RW-1:0]     row_p0;
    logic              accept_p0;
    logic              in_win_p0;
    logic              last_p0;
    logic [DATA_W-1:0] up1_p0;
    logic [DATA_W-1:0] up2_p0;

    assign accept_p0 = pix_valid && !rst;
    assign col_p0    = pix_sof ? '0 : col;
    assign row_p0    = pix_sof ? '0 : row;
    assign up1_p0    = lb1[col_p0];
    assign up2_p0    = lb2[col_p0];
    assign in_win_p0 = (row_p0 >= RW'(2)) && (col_p0 >= CW'(2));
    assign last_p0   = (row_p0 == ROW_LAST) && (col_p0 == COL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (col_p0 == COL_LAST) begin
                col <= '0;
                row <= (row_p0 == ROW_LAST) ? '0 : row_p0 + RW'(1);
            end else begin
                col <= col_p0 + CW'(1);
                row <= row_p0;
            end
        end
    end

    // Read-before-write: the reads above see the previous line's contents this cycle.
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            lb2[col_p0] <= up1_p0;
            lb1[col_p0] <= pix_in;
        end
    end

    // Stage p1: registered window; columns shift left on every accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            X1 <= '0; X2 <= '0; X3 <= '0;
            X4 <= '0; X5 <= '0; X6 <= '0;
            X7 <= '0; X8 <= '0; X9 <= '0;
        end else begin
            win_valid  <= pix_valid && in_win_p0;
            frame_done <= pix_valid && last_p0;
            if (pix_valid) begin
                X1 <= X2; X2 <= X3; X3 <= up2_p0;
                X4 <= X5; X5 <= X6; X6 <= up1_p0;
                X7 <= X8; X8 <= X9; X9 <= pix_in;
            end
        end
    end

endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen on a 5x4 image, checked every cycle
// against an image-array model, plus hand-computed window and median values.
module tb_median_window_gen;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid;
    logic       pix_sof;
    logic [7:0] pix_in;
    logic [7:0] X1, X2, X3, X4, X5, X6, X7, X8, X9;
    logic       win_valid;
    logic       frame_done;

    median_window_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .X1(X1), .X2(X2), .X3(X3), .X4(X4), .X5(X5), .X6(X6), .X7(X7), .X8(X8), .X9(X9),
        .win_valid(win_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int nwin = 0;
    int ndone = 0;
    logic checking = 1'b0;
    logic [71:0] wins[$];

    wire [71:0] dut_win = {X1, X2, X3, X4, X5, X6, X7, X8, X9};

    // Model: the current frame kept as a 2-D image; a window is the 3x3 block
    // ending at the accepted pixel's (row, col).
    logic [7:0]  img [H][W];
    int          m_row, m_col;
    logic        exp_valid, exp_done, exp_known;
    logic [71:0] exp_win;

    always @(posedge clk) begin : model
        int r, c;
        logic [71:0] w;
        if (rst) begin
            m_row <= 0; m_col <= 0;
            exp_valid <= 1'b0; exp_done <= 1'b0;
            exp_known <= 1'b1; exp_win <= '0;
        end else if (pix_valid) begin
            r = pix_sof ? 0 : m_row;
            c = pix_sof ? 0 : m_col;
            img[r][c] <= pix_in;
            w = '0;
            if (r >= 2 && c >= 2) begin
                for (int k = 0; k < 9; k++) begin
                    int rr, cc;
                    rr = r - 2 + k / 3;
                    cc = c - 2 + k % 3;
                    w[71-8*k -: 8] = (k == 8) ? pix_in : img[rr][cc];
                end
            end
            exp_valid <= (r >= 2 && c >= 2);
            exp_known <= (r >= 2 && c >= 2);
            exp_done  <= (r == H - 1 && c == W - 1);
            exp_win   <= w;
            if (c == W - 1) begin
                m_col <= 0;
                m_row <= (r == H - 1) ? 0 : r + 1;
            end else begin
                m_col <= c + 1;
                m_row <= r;
            end
        end else begin
            exp_valid <= 1'b0;
            exp_done  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            total++;
            if (win_valid !== exp_valid) begin
                bad++;
                $display("FAIL win_valid t=%0t got=%b want=%b", $time, win_valid, exp_valid);
            end
            total++;
            if (frame_done !== exp_done) begin
                bad++;
                $display("FAIL frame_done t=%0t got=%b want=%b", $time, frame_done, exp_done);
            end
            if (exp_known) begin
                total++;
                if (dut_win !== exp_win) begin
                    bad++;
                    $display("FAIL window t=%0t got=%h want=%h", $time, dut_win, exp_win);
                end
            end
            if (win_valid === 1'b1) begin
                wins.push_back(dut_win);
                nwin++;
            end
            if (frame_done === 1'b1) ndone++;
        end
    end

    function automatic logic [71:0] pack9(input int a, b, c, d, e, f, g, h, i);
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
    endfunction

    function automatic logic [7:0] median9(input logic [71:0] v);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int k = 0; k < 9; k++) a[k] = v[71-8*k -: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic cyc(input logic v, input logic s, input logic [7:0] p, input logic r);
        pix_valid = v; pix_sof = s; pix_in = p; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int off, input int mul, input bit toggle);
        for (int i = 0; i < W * H; i++) begin
            cyc(1'b1, i == 0, 8'((i * mul + off) % 256), 1'b0);
            if (toggle) cyc(1'b0, 1'b0, 8'hEE, 1'b0);
        end
    endtask

    function automatic logic [71:0] sw_win(input int cr, input int cc);
        logic [71:0] w;
        for (int k = 0; k < 9; k++)
            w[71-8*k -: 8] = 8'((((cr - 1 + k / 3) * W + (cc - 1 + k % 3)) * 7) % 256);
        return w;
    endfunction

    initial begin
        int w0, d0;
        rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0;
        @(posedge clk);
        #1;
        checking = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("reset_x", dut_win, '0);
        chk("reset_flags", {70'd0, win_valid, frame_done}, '0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);

        // continuous frame
        w0 = nwin; d0 = ndone;
        frame(0, 1, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0); cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("cont_count", 72'(nwin - w0), 72'd6);
        chk("cont_done", 72'(ndone - d0), 72'd1);
        chk("cont_first", wins[w0], pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
        chk("cont_last", wins[w0+5], pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));

        // pix_valid toggling
        w0 = nwin; d0 = ndone;
        frame(0, 1, 1'b1);
        chk("tog_count", 72'(nwin - w0), 72'd6);
        chk("tog_done", 72'(ndone - d0), 72'd1);
        chk("tog_first", wins[w0], pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
        chk("tog_last", wins[w0+5], pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));

        // back-to-back frames
        w0 = nwin; d0 = ndone;
        frame(0, 1, 1'b0);
        frame(100, 1, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("b2b_count", 72'(nwin - w0), 72'd12);
        chk("b2b_done", 72'(ndone - d0), 72'd2);
        chk("b2b_first2", wins[w0+6], pack9(100, 101, 102, 105, 106, 107, 110, 111, 112));

        // reset after pixel 13, pixel 14 presented with rst and dropped
        w0 = nwin; d0 = ndone;
        for (int i = 0; i < 14; i++) cyc(1'b1, i == 0, 8'(i), 1'b0);
        cyc(1'b1, 1'b0, 8'd14, 1'b1);
        chk("midrst_x", dut_win, '0);
        chk("midrst_valid", {71'd0, win_valid}, '0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_after_x", dut_win, '0);
        frame(50, 1, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_count", 72'(nwin - w0), 72'd8);
        chk("midrst_done", 72'(ndone - d0), 72'd1);
        chk("midrst_first", wins[w0+2], pack9(50, 51, 52, 55, 56, 57, 60, 61, 62));

        // pix_sof reasserted at pixel 8
        w0 = nwin; d0 = ndone;
        for (int i = 0; i < 8; i++) cyc(1'b1, i == 0, 8'(i), 1'b0);
        frame(200, 1, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("sof_count", 72'(nwin - w0), 72'd6);
        chk("sof_done", 72'(ndone - d0), 72'd1);
        chk("sof_first", wins[w0], pack9(200, 201, 202, 205, 206, 207, 210, 211, 212));

        // median of each window against a software 3x3 median
        w0 = nwin;
        frame(0, 7, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("med_count", 72'(nwin - w0), 72'd6);
        chk("med_first_lit", 72'(median9(wins[w0])), 72'd42);
        for (int i = 0; i < 6; i++)
            chk("med_window", 72'(median9(wins[w0+i])), 72'(median9(sw_win(1 + i / 3, 1 + i % 3))));

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/median_window_gen.md
Name: median_window_gen

Overview:
- Upstream neighbour of the 3x3 median network.
- Accepts a raster-order pixel stream (one pixel per valid cycle).
- Buffers two previous image lines in on-chip line buffers.
- Presents a registered 3x3 neighbourhood on X1..X9 with a window-valid strobe, for direct connection to the median network's pixel inputs.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 640, pixels per line (>=3).
- IMG_H, 480, lines per frame (>=3).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pix_in  input  DATA_W  incoming pixel, raster order.
- pix_valid  input  1  pix_in is valid this cycle; low = stall, no state change.
- pix_sof  input  1  start of frame; qualified by pix_valid; marks pixel (0,0).
- X1,X2,X3  output  DATA_W  window top row, left to right (line r-2).
- X4,X5,X6  output  DATA_W  window middle row, left to right (line r-1).
- X7,X8,X9  output  DATA_W  window bottom row, left to right (line r, current).
- win_valid  output  1  X1..X9 hold a complete in-image window this cycle.
- frame_done  output  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Reset: X1..X9 = 0, win_valid = 0, frame_done = 0, col = 0, row = 0. Line buffer RAM contents are not cleared; stale data is never exposed, because windows are gated by row >= 2.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only on pix_valid.
  - col wraps to 0 at IMG_W-1 and increments row.
  - row wraps to 0 after (IMG_H-1, IMG_W-1).
- pix_sof with pix_valid: the accepted pixel is treated as (0,0), regardless of current counters. Counters become col=1, row=0. Any partial frame is abandoned, with no frame_done.
- Line buffers: two, IMG_W deep, addressed by col.
  - On each accepted pixel, lb1[col] (line r-1) moves into lb2[col] (line r-2), and pix_in is written to lb1[col].
  - Reads and writes occur at the same address in the same cycle; the read returns the old value (read-before-write).
- Shift window: three columns of three registers.
  - On each accepted pixel the columns shift left.
  - The new right column is {lb2[col], lb1[col], pix_in} -> {X3, X6, X9}.
- Window validity: an accepted pixel at (row, col) with row >= 2 and col >= 2 produces a window centred on (row-1, col-1).
  - The next cycle has win_valid = 1 and X1..X9 = p(r-2..r, c-2..c).
  - Otherwise win_valid = 0 next cycle.
- Latency: 1 cycle from an accepting clk edge to win_valid/X outputs.
- Duration of outputs:
  - win_valid is high for exactly one cycle per qualifying pixel.
  - While pix_valid is low, win_valid = 0 and X1..X9 hold their last values.
- Border: no padding. Windows per frame = (IMG_W-2)*(IMG_H-2). Columns 0..1 of every line refill the shift window and never assert win_valid, so there is no wrap-around mixing across lines.
- frame_done: asserted with the win_valid generated by pixel (IMG_H-1, IMG_W-1).
- Reset mid-frame: counters cleared. The first window reappears only after two full new lines plus 3 pixels.
- Simultaneous rst and pix_valid: rst wins; the pixel is dropped.

Test Plan:
Common setup for all scenarios: IMG_W=5, IMG_H=4, p(r,c) = r*5+c, pix_sof on pixel 0.
- Continuous frame, pix_valid=1 -> exactly 6 win_valid pulses. The first follows pixel 12 with X1..X9 = 0,1,2,5,6,7,10,11,12. The last follows pixel 19 with X1..X9 = 7,8,9,12,13,14,17,18,19, and frame_done=1 in that cycle only.
- Same frame with pix_valid toggling 1/0 every cycle -> identical 6 windows in order. win_valid is never high in a cycle following pix_valid=0.
- Two back-to-back frames, second frame pixels offset by +100 -> second frame first window is 100,101,102,105,106,107,110,111,112. No window contains first-frame data.
- rst pulsed after pixel 13, then a new frame with pix_sof -> no win_valid until the new frame's pixel 12. Outputs read 0 during and immediately after reset.
- pix_sof reasserted at pixel 8 of a frame -> counters restart. No frame_done for the aborted frame. The next window follows the restarted frame's pixel 12.
- Chain into the median network with p(r,c) = (r*5+c)*7 mod 256 -> the median output matches a software 3x3 median at each win_valid.
